// File: rtl/cpu_pkg.sv
// Shared types and constants for the bare-bones CPU: fetch FSM states, datapath widths, opcodes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam int ADDR_WIDTH_C  = 8;
  localparam int INSTR_WIDTH_C = 32;
  localparam int PC_INC_C      = 4;

  localparam logic [6:0] OPC_BNE = 7'b1100011;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: sequential increment or PC-relative branch, modulo 2^ADDR_WIDTH.
// Also flags a taken branch with zero offset, which would spin on itself forever.
module next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_C,
  parameter int PC_INC     = PC_INC_C
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] imm_offset,
  input  logic                  taken,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  is_self_loop
);

  // Equal widths make the raw two's-complement add wrap exactly like a signed offset.
  assign pc_next      = taken ? (pc + imm_offset) : (pc + ADDR_WIDTH'(PC_INC));
  assign is_self_loop = taken && (imm_offset == '0);

endmodule

// File: rtl/pc_fetch.sv
// PC and instruction-fetch stage: IDLE -> REQ (held until ack) -> EXEC -> IDLE, parking in HALT on branch-to-self.
// Define PC_FETCH_PERF_EN to add saturating retired/stall counters.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_C,
  parameter int INSTR_WIDTH  = INSTR_WIDTH_C,
  parameter int PC_INC       = PC_INC_C,
  parameter int RESET_VECTOR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   branch_sel,
  input  logic                   eq,
  input  logic [ADDR_WIDTH-1:0]  imm_offset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   halted
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_retired,
  output logic [31:0]            perf_stall
`endif
);

  fetch_state_t           state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic                   req_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   halted_q;
  logic                   self_loop;
  logic                   taken;

  assign taken = branch_sel & eq;

  next_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_INC     (PC_INC)
  ) u_next_pc (
    .pc           (pc_q),
    .imm_offset   (imm_offset),
    .taken        (taken),
    .pc_next      (pc_d),
    .is_self_loop (self_loop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= ADDR_WIDTH'(RESET_VECTOR);
      req_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          // The request stays up regardless of en until memory answers.
          if (imem_ack) begin
            state_q <= EXEC;
            req_q   <= 1'b0;
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (self_loop) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= pc_d;
            state_q <= IDLE;
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // HALT is neither EXEC nor REQ, so both counters freeze there naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == EXEC && retired_q != '1) retired_q <= retired_q + 32'd1;
      if (state_q == REQ && !imem_ack && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: memory responder with programmable wait states, scoreboard of expected fetches.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        branch_sel;
  logic        eq;
  logic [7:0]  imm_offset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  logic        mem_ack = 1'b0;
  logic        stray_ack;
  logic        mem_on;
  int          mem_wait;
  int          mem_cnt = 0;
  logic [31:0] rdata_word;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [7:0] addr;
    logic       bs;
    logic       eqv;
    logic [7:0] imm;
    logic [7:0] exp_pc;
  } br_t;
  br_t tbl[14];

  always #5 clk = ~clk;

  assign imem_ack   = mem_ack | stray_ack;
  assign imem_rdata = rdata_word;

  pc_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .branch_sel  (branch_sel),
    .eq          (eq),
    .imm_offset  (imm_offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .halted      (halted)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory: acks after mem_wait idle request cycles.
  always @(negedge clk) begin
    if (mem_on && imem_req && !rst) begin
      if (mem_cnt >= mem_wait) begin
        mem_ack = 1'b1;
        mem_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(instr_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr_out, e.instr);
        chk("sb_pc", 32'(pc_out), 32'(e.addr));
      end
    end
  end

  task automatic fetch_one(input logic [7:0] addr, input logic bs, input logic eqv,
                           input logic [7:0] imm, input logic [7:0] exp_pc, input string tag);
    bit seen;
    seen       = 1'b0;
    branch_sel = bs;
    eq         = eqv;
    imm_offset = imm;
    rdata_word = 32'hC0DE_0000 | 32'(addr);
    sb.push_back('{addr, rdata_word});
    en = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (instr_valid) seen = 1'b1;
    end
    en = 1'b0;
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    step(1);
    chk({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; branch_sel = 1'b0; eq = 1'b0; imm_offset = 8'h00;
    stray_ack = 1'b0; mem_on = 1'b1; mem_wait = 0; rdata_word = 32'h0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_pc", 32'(pc_out), 32'h00);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", instr_out, 32'h0);

    // Reset while a request is outstanding, then a stray ack in IDLE.
    mem_on = 1'b0;
    en = 1'b1;
    step(1);
    chk("midreq_req", 32'(imem_req), 32'd1);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreq_rst_pc", 32'(pc_out), 32'h00);
    chk("midreq_rst_req", 32'(imem_req), 32'd0);
    chk("midreq_rst_valid", 32'(instr_valid), 32'd0);
    step(1);
    rst = 1'b0;
    rdata_word = 32'hDEAD_BEEF;
    stray_ack = 1'b1;
    step(2);
    stray_ack = 1'b0;
    chk("stray_instr", instr_out, 32'h0);
    chk("stray_valid", 32'(instr_valid), 32'd0);
    chk("stray_req", 32'(imem_req), 32'd0);
    chk("stray_pc", 32'(pc_out), 32'h00);
    mem_on = 1'b1;

    // Sequential zero-wait fetch.
    rdata_word = 32'h0000_0013;
    for (int k = 0; k < 4; k++) sb.push_back('{8'(4 * k), 32'h0000_0013});
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      chk("seq_valid", 32'(instr_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 1) chk("seq_addr", 32'(imem_addr), 32'(4 * (c / 3)));
    end
    en = 1'b0;
    chk("seq_pc_end", 32'(pc_out), 32'h10);

    // Wait states at 0x10 with en dropped during the wait.
    mem_wait = 4;
    rdata_word = 32'hA5A5_0001;
    sb.push_back('{8'h10, 32'hA5A5_0001});
    en = 1'b1;
    step(1);
    en = 1'b0;
    chk("wait_req", 32'(imem_req), 32'd1);
    chk("wait_addr", 32'(imem_addr), 32'h10);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'h10);
    end
    step(1);
    chk("wait_valid", 32'(instr_valid), 32'd1);
    step(1);
    chk("wait_pc", 32'(pc_out), 32'h14);
    chk("wait_req_done", 32'(imem_req), 32'd0);
    mem_wait = 0;

    // Branches, wrap-around and odd offsets, ending in a branch-to-self.
    tbl = '{
      '{8'h14, 1'b0, 1'b0, 8'h00, 8'h18},
      '{8'h18, 1'b0, 1'b0, 8'h00, 8'h1C},
      '{8'h1C, 1'b0, 1'b0, 8'h00, 8'h20},
      '{8'h20, 1'b1, 1'b1, 8'hF8, 8'h18},
      '{8'h18, 1'b0, 1'b0, 8'h00, 8'h1C},
      '{8'h1C, 1'b0, 1'b0, 8'h00, 8'h20},
      '{8'h20, 1'b1, 1'b0, 8'hF8, 8'h24},
      '{8'h24, 1'b1, 1'b1, 8'hFC, 8'h20},
      '{8'h20, 1'b0, 1'b1, 8'hF8, 8'h24},
      '{8'h24, 1'b1, 1'b1, 8'hD8, 8'hFC},
      '{8'hFC, 1'b0, 1'b0, 8'h00, 8'h00},
      '{8'h00, 1'b1, 1'b1, 8'h02, 8'h02},
      '{8'h02, 1'b1, 1'b1, 8'hFA, 8'hFC},
      '{8'hFC, 1'b1, 1'b1, 8'h00, 8'hFC}
    };
    for (int i = 0; i < 14; i++) begin
      fetch_one(tbl[i].addr, tbl[i].bs, tbl[i].eqv, tbl[i].imm, tbl[i].exp_pc, $sformatf("br%0d", i));
    end
    chk("halt_flag", 32'(halted), 32'd1);

    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("halt_req", 32'(imem_req), 32'd0);
    end
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc_out), 32'hFC);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst_flag", 32'(halted), 32'd0);
    chk("halt_rst_pc", 32'(pc_out), 32'h00);
    step(1);
    rst = 1'b0;
    step(1);

`ifdef PC_FETCH_PERF_EN
    chk("perf_rst_retired", perf_retired, 32'd0);
    chk("perf_rst_stall", perf_stall, 32'd0);
    mem_wait = 2;
    for (int k = 0; k < 5; k++) begin
      fetch_one(8'(4 * k), 1'b0, 1'b0, 8'h00, 8'(4 * k + 4), $sformatf("perf%0d", k));
    end
    chk("perf_retired", perf_retired, 32'd5);
    chk("perf_stall", perf_stall, 32'd10);
    rst = 1'b1;
    #1;
    chk("perf_clr_retired", perf_retired, 32'd0);
    chk("perf_clr_stall", perf_stall, 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter and instruction-fetch stage of the bare-bones CPU.
- Fetches one instruction at a time from instruction memory over a req/ack handshake and presents it to decode/execute.
- Takes the execute-stage branch decision (ALU `eq` flag plus decoder branch select) to choose the next PC.
- Detects a taken branch-to-self and parks in HALT.

Parameters:
- ADDR_WIDTH, 8, PC and instruction-address width; matches the 8-bit datapath.
- INSTR_WIDTH, 32, instruction word width.
- PC_INC, 4, sequential PC increment in bytes.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable; sampled only in IDLE.
- branch_sel  in  1  decoder: the current instruction is a conditional branch.
- eq  in  1  ALU compare flag; 1 = branch taken (bne semantics, operands differ).
- imm_offset  in  ADDR_WIDTH  branch offset, two's complement, bytes.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_WIDTH  fetch address; always equals pc_out.
- imem_ack  in  1  memory: imem_rdata valid this cycle.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- instr_out  out  INSTR_WIDTH  registered instruction to decode.
- instr_valid  out  1  one-cycle pulse: instr_out is newly loaded.
- pc_out  out  ADDR_WIDTH  current PC.
- halted  out  1  sticky HALT indication.

Behaviour:
- Reset (async, any state, including mid-request):
  - pc_out = RESET_VECTOR; state = IDLE.
  - imem_req = 0, instr_out = 0, instr_valid = 0, halted = 0.
  - An outstanding request is abandoned; an imem_ack arriving during or after reset in IDLE is ignored.
- States: IDLE, REQ, EXEC, HALT.
- IDLE:
  - imem_req = 0.
  - en = 1 -> REQ next cycle; en = 0 -> stay.
- REQ:
  - imem_req = 1, imem_addr = pc_out.
  - Request is held until imem_ack, independent of en; the request is never withdrawn.
  - On imem_ack: instr_out <= imem_rdata, instr_valid = 1 next cycle, -> EXEC.
  - Zero-wait memory (ack in the first REQ cycle) is legal.
- EXEC (exactly one cycle; branch_sel, eq and imm_offset are valid this cycle):
  - taken = branch_sel & eq.
  - taken & imm_offset == 0 -> HALT, halted <= 1, pc unchanged.
  - taken otherwise -> pc <= pc + imm_offset, -> IDLE.
  - not taken -> pc <= pc + PC_INC, -> IDLE.
- PC arithmetic:
  - Modulo 2^ADDR_WIDTH; wrap-around is silent. Example: 0xFC + 4 = 0x00; 0x02 + 0xFA = 0xFC.
  - imm_offset is added as a raw ADDR_WIDTH-bit value; no sign extension is needed at equal widths.
- HALT:
  - imem_req = 0, halted = 1.
  - Exit only via rst; en is ignored.
- Throughput: minimum 3 cycles per instruction (IDLE -> REQ -> EXEC) with continuous en and zero-wait memory.
- instr_out holds its value until the next ack; instr_valid is low in every cycle other than the one after an ack.
- branch_sel, eq and imm_offset are ignored outside EXEC.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - Adds output perf_retired [31:0], counting EXEC cycles.
  - Adds output perf_stall [31:0], counting REQ cycles with imem_ack = 0.
  - Both counters reset to 0 on rst, saturate at 0xFFFFFFFF, and freeze in HALT.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Package cpu_pkg:
  - fetch_state_t enum {IDLE, REQ, EXEC, HALT}.
  - Constants ADDR_WIDTH_C = 8, INSTR_WIDTH_C = 32, PC_INC_C = 4.
  - Opcode constant for bne, shared with the decoder and the ALU control.
- Sub-module next_pc: combinational.
  - Inputs: pc, imm_offset, taken.
  - Outputs: next pc and is_self_loop.
  - Instantiated once inside pc_fetch.

Test Plan:
- Reset: assert rst mid-REQ with imem_req = 1 -> same cycle pc_out = 0x00, imem_req = 0, instr_valid = 0; a following stray imem_ack in IDLE changes nothing.
- Sequential fetch: en = 1, zero-wait memory returning 0x00000013 -> imem_addr sequence 0x00, 0x04, 0x08; instr_valid pulses every 3 cycles; instr_out = 0x00000013.
- Wait states: ack delayed 4 cycles at pc 0x10 -> imem_req stays 1 and imem_addr stays 0x10 throughout, even with en = 0 during the wait; the fetch completes normally.
- Branch: pc 0x20, branch_sel = 1, eq = 1, imm_offset = 0xF8 -> next pc = 0x18. Same with eq = 0 -> next pc = 0x24. eq = 1 with branch_sel = 0 -> next pc = 0x24.
- Wrap and halt: pc 0xFC not taken -> pc = 0x00. Then a taken branch with imm_offset = 0 -> halted = 1, imem_req stays 0 with en = 1 for 10 cycles; rst clears halted.
- PC_FETCH_PERF_EN: 5 instructions, each with 2 wait cycles -> perf_retired = 5, perf_stall = 10; rst -> both counters 0.
